bram0_loader: RTL and testbench
===============================

Name: bram0_loader

Overview:
- Upstream feeder stage for the BRAM accumulator datapath.
- Accepts a valid/ready stream of IN_DATA_WIDTH-bit numbers and packs 4 consecutive numbers into one DWIDTH-bit row.
- Writes the rows sequentially into BRAM0 from address 0 and reports the number of rows written (row_count_o). Row count and per-row layout match what the BRAM0 consumer expects.

Parameters:
- CNT_BIT, 31, width of load_count_i and the element counters
- DWIDTH, 32, BRAM0 row width; must equal 4*IN_DATA_WIDTH
- AWIDTH, 8, BRAM0 address width
- MEM_SIZE, 256, BRAM0 depth in rows
- IN_DATA_WIDTH, 8, width of one input number

Ports:
- clk  input  1  clock, all logic on rising edge
- reset_n  input  1  asynchronous active-low reset
- start_load_i  input  1  active-high start pulse, sampled in IDLE only
- load_count_i  input  CNT_BIT  number of input elements to load, latched on start
- s_valid_i  input  1  input element valid
- s_data_i  input  IN_DATA_WIDTH  input element
- s_ready_o  output  1  loader can accept an element this cycle
- idle_o  output  1  state == IDLE
- run_o  output  1  state == RUN or FLUSH
- done_o  output  1  state == DONE, exactly one cycle
- overflow_o  output  1  sticky: load_count_i exceeded 4*MEM_SIZE; cleared on next accepted start
- row_count_o  output  AWIDTH+1  rows written in the current/last load; held until next start
- addr_b0_o  output  AWIDTH  BRAM0 address
- ce_b0_o  output  1  BRAM0 chip enable
- we_b0_o  output  1  BRAM0 write enable
- d_b0_o  output  DWIDTH  BRAM0 write data

Behaviour:
- Reset (asynchronous, any state): state=IDLE, idle_o=1, all other outputs 0, counters and pack register cleared.
- States are IDLE, RUN, FLUSH and DONE. State outputs are decoded from a registered state.
- IDLE:
  - On start_load_i=1: latch eff_count = min(load_count_i, 4*MEM_SIZE).
  - Set overflow_o if load_count_i > 4*MEM_SIZE, else clear it.
  - Clear row_count_o, element counter and lane.
  - If load_count_i==0, go to DONE; otherwise go to RUN.
- RUN:
  - s_ready_o=1 while accepted < eff_count; it is combinational from state and counter only, never from s_valid_i.
  - A transfer occurs when s_valid_i && s_ready_o. The k-th accepted element (k from 0) goes to lane k%4, bits [IN_DATA_WIDTH*(k%4) +: IN_DATA_WIDTH].
  - Row commit: when lane 3 is accepted, or when the last element (k==eff_count-1) is accepted.
  - On the next cycle after a commit, ce_b0_o=1, we_b0_o=1, addr_b0_o=row index, d_b0_o=packed row, all for exactly one cycle.
  - Unfilled lanes of a partial final row are 0. The pack register clears after each commit.
  - row_count_o increments in the cycle the write pulse is driven.
  - Accepting the last element moves the state to FLUSH.
  - Back-to-back transfers at full rate are sustained (1 element/cycle, 1 row write per 4 cycles); no backpressure from the write port.
- FLUSH: drive the final write pulse (1 cycle), s_ready_o=0, then go to DONE.
- DONE: done_o=1 for one cycle, then go to IDLE.
- Latency: last element accepted at cycle T → final write at T+1 → done_o at T+2 → idle_o at T+3.
- Outside a write pulse: ce_b0_o=we_b0_o=0, and addr_b0_o and d_b0_o are held at their last values.
- This block never reads BRAM0, so we_b0_o=1 whenever ce_b0_o=1.
- start_load_i outside IDLE is ignored, including in the same cycle as done_o.
- s_valid_i while s_ready_o=0 is ignored; the element is not consumed.
- Address never exceeds MEM_SIZE-1. With overflow the load stops after 4*MEM_SIZE elements, and row_count_o=MEM_SIZE.
- Reset asserted mid-load aborts immediately with no further writes. BRAM contents already written are left as-is.

Test Plan:
- Start with load_count_i=8 and stream 0x01..0x08 back-to-back → exactly 2 writes: addr 0 d=0x04030201, addr 1 d=0x08070605. done_o 2 cycles after the 8th transfer; row_count_o=2.
- load_count_i=6 with data 0xA0..0xA5 → addr 0 d=0xA3A2A1A0, addr 1 d=0x0000A5A4; row_count_o=2.
- load_count_i=4 with s_valid_i toggling every other cycle → a single write, addr 0 d=packed value, after the 4th accepted element only. s_ready_o drops to 0 after the 4th acceptance.
- load_count_i=0 → no ce_b0_o pulse; done_o the cycle after start, then idle_o; row_count_o=0.
- load_count_i=1030 → overflow_o=1, 1024 elements accepted, last write at addr 255, row_count_o=256, s_ready_o=0 afterwards.
- Assert reset_n=0 after 5 of 8 elements → exactly 1 write seen (addr 0), all outputs at reset values, idle_o=1. A fresh start then loads correctly from addr 0.

Source files
------------

// File: rtl/bram0_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : bram0_loader_if
// Description : Valid/ready element stream feeding the BRAM0 loader.
//               master modport : element producer (drives valid/data)
//               slave modport  : bram0_loader (drives ready)
// Signals     : s_valid_i  element valid
//               s_data_i   element value, IN_DATA_WIDTH bits
//               s_ready_o  loader accepts an element this cycle
// Revision    : 1.0 - initial release
// ============================================================================
interface bram0_loader_if #(
    parameter int IN_DATA_WIDTH = 8
) ();
    logic                     s_valid_i;
    logic [IN_DATA_WIDTH-1:0] s_data_i;
    logic                     s_ready_o;

    modport master (
        output s_valid_i,
        output s_data_i,
        input  s_ready_o
    );

    modport slave (
        input  s_valid_i,
        input  s_data_i,
        output s_ready_o
    );
endinterface
`default_nettype wire

// File: rtl/bram0_loader.sv
`default_nettype none
// ============================================================================
// Module      : bram0_loader
// Description : Packs 4 consecutive stream elements into one DWIDTH-bit row
//               and writes the rows into BRAM0 from address 0 upwards.
// Ports       : clk, reset_n          clock / async active-low reset
//               start_load_i          start pulse, honoured in IDLE only
//               load_count_i          number of elements to load
//               s_if (slave)          element stream (valid/data/ready)
//               idle_o/run_o/done_o   state flags
//               overflow_o            load_count_i exceeded 4*MEM_SIZE
//               row_count_o           rows written by the current/last load
//               addr_b0_o/ce_b0_o/we_b0_o/d_b0_o  BRAM0 write port
// Revision    : 1.0 - initial release
// ============================================================================
module bram0_loader #(
    parameter int CNT_BIT       = 31,
    parameter int DWIDTH        = 32,
    parameter int AWIDTH        = 8,
    parameter int MEM_SIZE      = 256,
    parameter int IN_DATA_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start_load_i,
    input  logic [CNT_BIT-1:0]  load_count_i,
    bram0_loader_if.slave       s_if,
    output logic                idle_o,
    output logic                run_o,
    output logic                done_o,
    output logic                overflow_o,
    output logic [AWIDTH:0]     row_count_o,
    output logic [AWIDTH-1:0]   addr_b0_o,
    output logic                ce_b0_o,
    output logic                we_b0_o,
    output logic [DWIDTH-1:0]   d_b0_o
);

    localparam logic [CNT_BIT-1:0] c_MAX_ELEMS = CNT_BIT'(4 * MEM_SIZE);
    localparam logic [CNT_BIT-1:0] c_CNT_ONE   = CNT_BIT'(1);
    localparam logic [AWIDTH:0]    c_ROW_ONE   = (AWIDTH+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [CNT_BIT-1:0]   r_eff_count;
    logic [CNT_BIT-1:0]   r_accepted;
    logic [1:0]           r_lane;
    logic [DWIDTH-1:0]    r_pack;
    logic                 r_overflow;
    logic [AWIDTH:0]      r_row_count;
    logic [AWIDTH-1:0]    r_addr;
    logic [DWIDTH-1:0]    r_data;
    logic                 r_ce;

    logic                 w_start;
    logic                 w_ready;
    logic                 w_fire;
    logic                 w_last;
    logic                 w_commit;
    logic [DWIDTH-1:0]    w_pack_next;

    // Ready depends only on state and the element counter so the producer
    // never sees a combinational path from its own valid.
    assign w_start  = (r_state == S_IDLE) && start_load_i;
    assign w_ready  = (r_state == S_RUN) && (r_accepted < r_eff_count);
    assign w_fire   = w_ready && s_if.s_valid_i;
    assign w_last   = w_fire && (r_accepted == (r_eff_count - c_CNT_ONE));
    assign w_commit = w_fire && ((r_lane == 2'd3) || w_last);

    assign s_if.s_ready_o = w_ready;

    // Current row with the incoming element merged into its lane.
    always_comb begin
        w_pack_next = r_pack;
        for (int l = 0; l < 4; l++) begin
            if (r_lane == 2'(l)) begin
                w_pack_next[l*IN_DATA_WIDTH +: IN_DATA_WIDTH] = s_if.s_data_i;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        w_state_next = r_state;
        idle_o       = 1'b0;
        run_o        = 1'b0;
        done_o       = 1'b0;
        case (r_state)
            S_IDLE: begin
                idle_o = 1'b1;
                if (start_load_i) begin
                    w_state_next = (load_count_i == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                run_o = 1'b1;
                if (w_last) begin
                    w_state_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                run_o        = 1'b1;
                w_state_next = S_DONE;
            end
            S_DONE: begin
                done_o       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: counters, pack register and the one-cycle write pulse.
    // The row counter doubles as the write address, so it is advanced on
    // the same edge that raises the write pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_eff_count <= '0;
            r_accepted  <= '0;
            r_lane      <= 2'd0;
            r_pack      <= '0;
            r_overflow  <= 1'b0;
            r_row_count <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_ce        <= 1'b0;
        end else begin
            r_ce <= 1'b0;
            if (w_start) begin
                r_eff_count <= (load_count_i > c_MAX_ELEMS) ? c_MAX_ELEMS : load_count_i;
                r_overflow  <= (load_count_i > c_MAX_ELEMS);
                r_row_count <= '0;
                r_accepted  <= '0;
                r_lane      <= 2'd0;
                r_pack      <= '0;
            end
            if (w_fire) begin
                r_accepted <= r_accepted + c_CNT_ONE;
                if (w_commit) begin
                    r_pack      <= '0;
                    r_lane      <= 2'd0;
                    r_ce        <= 1'b1;
                    r_addr      <= r_row_count[AWIDTH-1:0];
                    r_data      <= w_pack_next;
                    r_row_count <= r_row_count + c_ROW_ONE;
                end else begin
                    r_pack <= w_pack_next;
                    r_lane <= r_lane + 2'd1;
                end
            end
        end
    end

    assign overflow_o  = r_overflow;
    assign row_count_o = r_row_count;
    assign addr_b0_o   = r_addr;
    assign d_b0_o      = r_data;
    assign ce_b0_o     = r_ce;
    assign we_b0_o     = r_ce;

endmodule
`default_nettype wire

// File: tb/tb_bram0_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram0_loader
// Description : Self-checking bench for bram0_loader. A behavioural model
//               stores accepted elements in an array and derives each row
//               write, the row count and the state flags from them; a
//               negedge process compares every DUT output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram0_loader;

    localparam int CNT_BIT  = 31;
    localparam int DWIDTH   = 32;
    localparam int AWIDTH   = 8;
    localparam int MEM_SIZE = 256;
    localparam int IN_W     = 8;
    localparam int MAXE     = 4 * MEM_SIZE;
    localparam int BUDGET   = 3000;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               start_load_i = 1'b0;
    logic [CNT_BIT-1:0] load_count_i = '0;
    logic               idle_o, run_o, done_o, overflow_o;
    logic [AWIDTH:0]    row_count_o;
    logic [AWIDTH-1:0]  addr_b0_o;
    logic               ce_b0_o, we_b0_o;
    logic [DWIDTH-1:0]  d_b0_o;

    bram0_loader_if #(.IN_DATA_WIDTH(IN_W)) s_if ();

    bram0_loader #(
        .CNT_BIT(CNT_BIT), .DWIDTH(DWIDTH), .AWIDTH(AWIDTH),
        .MEM_SIZE(MEM_SIZE), .IN_DATA_WIDTH(IN_W)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .start_load_i(start_load_i), .load_count_i(load_count_i),
        .s_if(s_if),
        .idle_o(idle_o), .run_o(run_o), .done_o(done_o),
        .overflow_o(overflow_o), .row_count_o(row_count_o),
        .addr_b0_o(addr_b0_o), .ce_b0_o(ce_b0_o), .we_b0_o(we_b0_o),
        .d_b0_o(d_b0_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int              m_eff = 0;
    int              m_acc = 0;
    int              m_tail = 0;     // 1: final-write cycle, 2: done cycle
    bit              m_loading = 1'b0;
    logic [IN_W-1:0] m_elem [0:MAXE-1];

    bit              e_idle = 1'b1, e_run = 1'b0, e_done = 1'b0;
    bit              e_ready = 1'b0, e_ce = 1'b0, e_ovf = 1'b0;
    logic [AWIDTH:0]   e_rows = '0;
    logic [AWIDTH-1:0] e_addr = '0;
    logic [DWIDTH-1:0] e_data = '0;

    function automatic logic [DWIDTH-1:0] pack_row(input int r);
        logic [DWIDTH-1:0] v;
        v = '0;
        for (int l = 0; l < 4; l++) begin
            if (4*r + l < m_eff) v[l*IN_W +: IN_W] = m_elem[4*r + l];
        end
        return v;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_eff = 0; m_acc = 0; m_tail = 0; m_loading = 1'b0;
            e_idle = 1'b1; e_run = 1'b0; e_done = 1'b0; e_ready = 1'b0;
            e_ce = 1'b0; e_ovf = 1'b0; e_rows = '0; e_addr = '0; e_data = '0;
        end else begin
            e_ce = 1'b0;
            if (m_tail == 1) begin
                m_tail = 2;
            end else if (m_tail == 2) begin
                m_tail = 0;
            end else if (m_loading) begin
                if (s_if.s_valid_i) begin
                    m_elem[m_acc] = s_if.s_data_i;
                    m_acc++;
                    if ((m_acc % 4 == 0) || (m_acc == m_eff)) begin
                        e_ce   = 1'b1;
                        e_addr = AWIDTH'((m_acc - 1) / 4);
                        e_data = pack_row((m_acc - 1) / 4);
                        e_rows = (AWIDTH+1)'((m_acc - 1) / 4 + 1);
                    end
                    if (m_acc == m_eff) begin
                        m_loading = 1'b0;
                        m_tail    = 1;
                    end
                end
            end else if (start_load_i) begin
                m_eff  = (load_count_i > CNT_BIT'(MAXE)) ? MAXE : int'(load_count_i);
                e_ovf  = (load_count_i > CNT_BIT'(MAXE));
                e_rows = '0;
                m_acc  = 0;
                if (m_eff == 0) m_tail = 2;
                else            m_loading = 1'b1;
            end
            e_idle  = !m_loading && (m_tail == 0);
            e_run   = m_loading || (m_tail == 1);
            e_done  = (m_tail == 2);
            e_ready = m_loading && (m_acc < m_eff);
        end
    end

    // ---------------- compare process + write log ----------------
    int                cyc = 0;
    int                wlog_n = 0;
    logic [AWIDTH-1:0] wlog_a [0:299];
    logic [DWIDTH-1:0] wlog_d [0:299];
    int                last_wr_cyc = -1;
    int                done_cyc = -1;

    always @(negedge clk) begin
        cyc++;
        chk("idle_o",      64'(idle_o),      64'(e_idle));
        chk("run_o",       64'(run_o),       64'(e_run));
        chk("done_o",      64'(done_o),      64'(e_done));
        chk("s_ready_o",   64'(s_if.s_ready_o), 64'(e_ready));
        chk("ce_b0_o",     64'(ce_b0_o),     64'(e_ce));
        chk("we_b0_o",     64'(we_b0_o),     64'(e_ce));
        chk("addr_b0_o",   64'(addr_b0_o),   64'(e_addr));
        chk("d_b0_o",      64'(d_b0_o),      64'(e_data));
        chk("row_count_o", 64'(row_count_o), 64'(e_rows));
        chk("overflow_o",  64'(overflow_o),  64'(e_ovf));
        if (ce_b0_o === 1'b1) begin
            if (wlog_n < 300) begin
                wlog_a[wlog_n] = addr_b0_o;
                wlog_d[wlog_n] = d_b0_o;
            end
            wlog_n++;
            last_wr_cyc = cyc;
        end
        if (done_o === 1'b1) done_cyc = cyc;
    end

    // ---------------- stimulus ----------------
    // vmode: 0 full rate, 1 valid every other cycle, 2 random valid
    // dmode: 0 data = dbase + element index, 1 random data
    task automatic run_load(input int cnt, input int vmode, input int dmode,
                            input int dbase, input int rst_at, input bit start_in_done);
        int n;
        wlog_n   = 0;
        done_cyc = -1;
        @(negedge clk);
        start_load_i = 1'b1;
        load_count_i = CNT_BIT'(cnt);
        s_if.s_valid_i = 1'b0;
        @(negedge clk);
        start_load_i = 1'b0;
        n = 0;
        while (!e_idle && n < BUDGET) begin
            if (rst_at >= 0 && m_acc == rst_at) begin
                s_if.s_valid_i = 1'b0;
                #2 reset_n = 1'b0;
                @(negedge clk);
                chk("rst_idle", 64'(idle_o), 64'd1);
                chk("rst_rows", 64'(row_count_o), 64'd0);
                @(negedge clk);
                #2 reset_n = 1'b1;
                break;
            end
            case (vmode)
                0:       s_if.s_valid_i = 1'b1;
                1:       s_if.s_valid_i = (n % 2 == 0);
                default: s_if.s_valid_i = ($urandom_range(0, 3) != 0);
            endcase
            s_if.s_data_i = (dmode == 0) ? IN_W'(dbase + m_acc) : IN_W'($urandom);
            start_load_i  = start_in_done && e_done;
            @(negedge clk);
            n++;
        end
        start_load_i   = 1'b0;
        s_if.s_valid_i = 1'b0;
        chk("load_finished", 64'(n < BUDGET), 64'd1);
    endtask

    initial begin
        int c;
        s_if.s_valid_i = 1'b0;
        s_if.s_data_i  = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        chk("reset_idle", 64'(idle_o), 64'd1);
        chk("reset_ce",   64'(ce_b0_o), 64'd0);

        // 8 elements 0x01..0x08, start pulsed during done (must be ignored)
        run_load(8, 0, 0, 1, -1, 1'b1);
        chk("t1_writes", 64'(wlog_n), 64'd2);
        chk("t1_a0", 64'(wlog_a[0]), 64'd0);
        chk("t1_d0", 64'(wlog_d[0]), 64'h04030201);
        chk("t1_a1", 64'(wlog_a[1]), 64'd1);
        chk("t1_d1", 64'(wlog_d[1]), 64'h08070605);
        chk("t1_rows", 64'(row_count_o), 64'd2);
        chk("t1_done_lat", 64'(done_cyc - last_wr_cyc), 64'd1);

        // partial final row
        run_load(6, 0, 0, 'hA0, -1, 1'b0);
        chk("t2_d0", 64'(wlog_d[0]), 64'hA3A2A1A0);
        chk("t2_d1", 64'(wlog_d[1]), 64'h0000A5A4);
        chk("t2_rows", 64'(row_count_o), 64'd2);

        // toggling valid, single row
        run_load(4, 1, 0, 'h30, -1, 1'b0);
        chk("t3_writes", 64'(wlog_n), 64'd1);
        chk("t3_d0", 64'(wlog_d[0]), 64'h33323130);

        // zero-length load
        run_load(0, 0, 0, 0, -1, 1'b0);
        chk("t4_writes", 64'(wlog_n), 64'd0);
        chk("t4_rows", 64'(row_count_o), 64'd0);
        chk("t4_done_seen", 64'(done_cyc >= 0), 64'd1);

        // overflow
        run_load(1030, 0, 1, 0, -1, 1'b0);
        chk("t5_ovf", 64'(overflow_o), 64'd1);
        chk("t5_rows", 64'(row_count_o), 64'd256);
        chk("t5_writes", 64'(wlog_n), 64'd256);
        chk("t5_last_addr", 64'(wlog_a[255]), 64'd255);
        chk("t5_ready", 64'(s_if.s_ready_o), 64'd0);

        // overflow cleared by next accepted start
        run_load(0, 0, 0, 0, -1, 1'b0);
        chk("t6_ovf", 64'(overflow_o), 64'd0);

        // reset after 5 of 8 elements
        run_load(8, 0, 0, 0, 5, 1'b0);
        chk("t7_writes", 64'(wlog_n), 64'd1);
        chk("t7_a0", 64'(wlog_a[0]), 64'd0);
        chk("t7_idle", 64'(idle_o), 64'd1);

        // fresh load after reset
        run_load(8, 0, 0, 'h11, -1, 1'b0);
        chk("t8_a0", 64'(wlog_a[0]), 64'd0);
        chk("t8_d0", 64'(wlog_d[0]), 64'h14131211);

        // randomized loads
        for (int i = 0; i < 8; i++) begin
            c = int'($urandom_range(1, 40));
            run_load(c, 2, 1, 0, -1, 1'($urandom_range(0, 1)));
            chk("rnd_writes", 64'(wlog_n), 64'((c + 3) / 4));
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
